// File: rtl/mem_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Front end for the unified 16-bit, big-endian, byte-addressed instruction/data
// memory. Two requesting channels share the memory's single port:
//   * instruction fetch (if_*)
//   * load/store        (d_*)
// Each request is checked for alignment and region when it is granted. A
// faulting request never reaches the memory and is answered on the next cycle.
// A legal request is serialised onto the registered memory pins, and the
// combinational memory result is captured. Every request is answered with a
// one-cycle ack pulse on its own channel.
//
// Ports
//   clk, rest        clock; asynchronous active-high reset
//   if_req/if_addr   fetch request (held until if_ack) and byte address
//   if_ack/if_rdata/if_fault
//                    completion pulse, fetched word, region/alignment fault
//   d_req/d_we/d_addr/d_wdata
//                    data request (held until d_ack), store flag, address, data
//   d_ack/d_rdata/d_fault
//                    completion pulse, loaded word (0 for stores), fault
//   mem_address/mem_read/mem_write/mem_write_data
//                    registered memory pins
//   mem_result       combinational read data from the memory
//   busy             FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int IMEM_TOP       = 1023,
  parameter int DMEM_BASE      = 1024,
  parameter int DMEM_TOP       = 4095,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_fault,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_result,
  output logic        busy
);

  localparam int             BW         = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX  = BW'(MAX_DATA_BURST);
  localparam logic [16:0]    IMEM_TOP_L = 17'(IMEM_TOP);
  localparam logic [16:0]    DMEM_BASE_L = 17'(DMEM_BASE);
  localparam logic [16:0]    DMEM_TOP_L = 17'(DMEM_TOP);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    STORE     = 3'd3,
    STORE_REL = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          if_ack_q, if_ack_d;
  logic          if_fault_q, if_fault_d;
  logic [15:0]   if_rdata_q, if_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_fault_q, d_fault_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic [15:0]   mem_address_q, mem_address_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [15:0]   mem_write_data_q, mem_write_data_d;

  // Region / alignment checks. The +1 is done 17 bits wide so that 0xFFFF
  // cannot wrap around into a legal range.
  logic [16:0] if_addr_p1, d_addr_p1;
  logic        if_legal, d_legal;

  assign if_addr_p1 = {1'b0, if_addr} + 17'd1;
  assign d_addr_p1  = {1'b0, d_addr} + 17'd1;
  assign if_legal   = ~if_addr[0] & (if_addr_p1 <= IMEM_TOP_L);
  assign d_legal    = ~d_addr[0] & ({1'b0, d_addr} >= DMEM_BASE_L) & (d_addr_p1 <= DMEM_TOP_L);

  // Arbitration. A channel whose ack is showing this cycle is not eligible,
  // because its requester may still be holding the old request. Data has
  // priority: a raised d_req (even one that is locked out) holds off the fetch
  // unless the burst limit is reached, so a data requester streaming
  // back-to-back accesses keeps the port until MAX_DATA_BURST grants.
  logic if_pend, d_pend, burst_full, grant_if, grant_d;

  assign if_pend    = if_req & ~if_ack_q;
  assign d_pend     = d_req & ~d_ack_q;
  assign burst_full = (burst_q == BURST_MAX);
  assign grant_if   = (state_q == IDLE) & if_pend & (burst_full | ~d_req);
  assign grant_d    = (state_q == IDLE) & d_pend & ~grant_if;

  // State register (all registered outputs included).
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q          <= IDLE;
      burst_q          <= '0;
      if_ack_q         <= 1'b0;
      if_fault_q       <= 1'b0;
      if_rdata_q       <= 16'h0000;
      d_ack_q          <= 1'b0;
      d_fault_q        <= 1'b0;
      d_rdata_q        <= 16'h0000;
      mem_address_q    <= 16'h0000;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_write_data_q <= 16'h0000;
    end else begin
      state_q          <= state_d;
      burst_q          <= burst_d;
      if_ack_q         <= if_ack_d;
      if_fault_q       <= if_fault_d;
      if_rdata_q       <= if_rdata_d;
      d_ack_q          <= d_ack_d;
      d_fault_q        <= d_fault_d;
      d_rdata_q        <= d_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Next-state logic: FSM and burst counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_if && if_legal) begin
          state_d = FETCH;
        end else if (grant_d && d_legal) begin
          state_d = d_we ? STORE : LOAD;
        end
      end
      FETCH:     state_d = IDLE;
      LOAD:      state_d = IDLE;
      STORE:     state_d = STORE_REL;
      STORE_REL: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Counts data grants made while a fetch is waiting; faulting data grants
    // count as grants too.
    burst_d = burst_q;
    if (!if_req || grant_if) begin
      burst_d = '0;
    end else if (grant_d && !burst_full) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    if_ack_d         = 1'b0;
    if_fault_d       = 1'b0;
    if_rdata_d       = if_rdata_q;
    d_ack_d          = 1'b0;
    d_fault_d        = 1'b0;
    d_rdata_d        = d_rdata_q;
    mem_address_d    = 16'h0000;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_write_data_d = 16'h0000;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          if (if_legal) begin
            mem_address_d = if_addr;
          end else begin
            if_ack_d   = 1'b1;
            if_fault_d = 1'b1;
            if_rdata_d = 16'h0000;
          end
        end else if (grant_d) begin
          if (d_legal) begin
            mem_address_d    = d_addr;
            mem_read_d       = ~d_we;
            mem_write_d      = d_we;
            mem_write_data_d = d_we ? d_wdata : 16'h0000;
          end else begin
            d_ack_d   = 1'b1;
            d_fault_d = 1'b1;
            d_rdata_d = 16'h0000;
          end
        end
      end
      FETCH: begin
        if_ack_d   = 1'b1;
        if_rdata_d = mem_result;
      end
      LOAD: begin
        d_ack_d   = 1'b1;
        d_rdata_d = mem_result;
      end
      STORE: begin
        // Write strobe drops, address and data stay put for one release cycle.
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
      end
      STORE_REL: begin
        d_ack_d   = 1'b1;
        d_rdata_d = 16'h0000;
      end
      default: ;
    endcase
  end

  assign if_ack         = if_ack_q;
  assign if_fault       = if_fault_q;
  assign if_rdata       = if_rdata_q;
  assign d_ack          = d_ack_q;
  assign d_fault        = d_fault_q;
  assign d_rdata        = d_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = (state_q != IDLE);

endmodule
